// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signals of the load/store unit
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] mem_read_addr;
   logic [31:0] mem_read_data;
   logic [31:0] mem_write_addr;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;

   modport slave (
      input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_fault,
      output mem_read_addr, mem_write_addr, mem_write_data, mem_write_enable
   );

   modport master (
      output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_fault,
      input  mem_read_addr, mem_write_addr, mem_write_data, mem_write_enable
   );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with fault checks and read-modify-write sub-word stores
module load_store_unit #(
   parameter int MEM_BYTES = 512
) (
   input logic              clk,
   input logic              reset,
   load_store_unit_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD_WAIT, MERGE, WRITE, RESP} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [15:0] wdata_q, wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_fault_q, resp_fault_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_waddr_q, mem_waddr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic        handshake;
   logic        illegal, misaligned, out_of_range, fault;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] merged;

   assign handshake = bus.req_valid && (state_q == IDLE);

   always_comb begin
      if (bus.req_is_store)
         illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
      else
         illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
      out_of_range = bus.req_addr >= 32'(MEM_BYTES);
      fault        = illegal || misaligned || out_of_range;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         funct3_q     <= '0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_fault_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_waddr_q  <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         funct3_q     <= funct3_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_fault_q <= resp_fault_d;
         mem_we_q     <= mem_we_d;
         mem_waddr_q  <= mem_waddr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (fault)                         state_d = RESP;
               else if (!bus.req_is_store)        state_d = LOAD_WAIT;
               else if (bus.req_funct3 == 3'b010) state_d = WRITE;
               else                               state_d = MERGE;
            end
         end
         LOAD_WAIT: state_d = RESP;
         MERGE:     state_d = WRITE;
         WRITE:     state_d = RESP;
         RESP:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      ld_byte = bus.mem_read_data[{addr_q[1:0], 3'b000} +: 8];
      ld_half = addr_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
      merged  = bus.mem_read_data;
      if (funct3_q[1:0] == 2'b00)
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];

      addr_d       = addr_q;
      funct3_d     = funct3_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_fault_d = 1'b0;
      mem_we_d     = 1'b0;
      mem_waddr_d  = mem_waddr_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (handshake) begin
               addr_d   = bus.req_addr;
               funct3_d = bus.req_funct3;
               wdata_d  = bus.req_wdata[15:0];
               if (fault) begin
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
               end else if (bus.req_is_store && (bus.req_funct3 == 3'b010)) begin
                  mem_we_d    = 1'b1;
                  mem_waddr_d = {bus.req_addr[31:2], 2'b00};
                  mem_wdata_d = bus.req_wdata;
               end
            end
         end
         LOAD_WAIT: begin
            resp_valid_d = 1'b1;
            case (funct3_q)
               3'b000:  resp_rdata_d = {{24{ld_byte[7]}}, ld_byte};
               3'b100:  resp_rdata_d = {24'b0, ld_byte};
               3'b001:  resp_rdata_d = {{16{ld_half[15]}}, ld_half};
               3'b101:  resp_rdata_d = {16'b0, ld_half};
               default: resp_rdata_d = bus.mem_read_data;
            endcase
         end
         MERGE: begin
            mem_we_d    = 1'b1;
            mem_waddr_d = {addr_q[31:2], 2'b00};
            mem_wdata_d = merged;
         end
         WRITE:   resp_valid_d = 1'b1;
         default: ;
      endcase
   end

   assign bus.req_ready        = (state_q == IDLE);
   assign bus.mem_read_addr    = (state_q == IDLE) ? {bus.req_addr[31:2], 2'b00} : {addr_q[31:2], 2'b00};
   assign bus.resp_valid       = resp_valid_q;
   assign bus.resp_rdata       = resp_rdata_q;
   assign bus.resp_fault       = resp_fault_q;
   assign bus.mem_write_addr   = mem_waddr_q;
   assign bus.mem_write_data   = mem_wdata_q;
   // Masked by reset so a store caught in WRITE never reaches memory.
   assign bus.mem_write_enable = mem_we_q && !reset;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
   localparam int MEM_BYTES = 512;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_if bus();

   load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // data memory: registered read, read-before-write
   logic [31:0] mem [0:127] = '{default: '0};
   always @(posedge clk) begin
      bus.mem_read_data <= mem[bus.mem_read_addr[8:2]];
      if (bus.mem_write_enable) mem[bus.mem_write_addr[8:2]] <= bus.mem_write_data;
   end

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // behavioural model: byte-addressed memory image and one pending transaction
   logic [7:0]  ref_mem [0:MEM_BYTES-1] = '{default: '0};
   int          exp_resp_cyc = -1;
   int          exp_we_cyc   = -1;
   int          busy_until   = -1;
   logic [31:0] exp_rdata = '0, exp_waddr = '0, exp_wdata = '0;
   logic        exp_fault = 1'b0;
   int          n_accepted = 0;
   int          n_resp     = 0;
   bit          after_reset = 1'b0;

   task automatic model_accept(input int c0);
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a, wd, v;
      int          size;
      bit          legal, flt;
      st = bus.req_is_store;
      f3 = bus.req_funct3;
      a  = bus.req_addr;
      wd = bus.req_wdata;
      legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      flt   = !legal || (a % size != 0) || (a >= MEM_BYTES);
      n_accepted++;
      if (flt) begin
         exp_resp_cyc = c0 + 1;
         exp_rdata    = '0;
         exp_fault    = 1'b1;
      end else if (!st) begin
         v = '0;
         for (int i = 0; i < size; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
         if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
         exp_resp_cyc = c0 + 2;
         exp_rdata    = v;
         exp_fault    = 1'b0;
      end else begin
         exp_waddr = a & ~32'd3;
         for (int i = 0; i < 4; i++) exp_wdata[8 * i +: 8] = ref_mem[exp_waddr + i];
         for (int i = 0; i < size; i++) exp_wdata[8 * ((a % 4) + i) +: 8] = wd[8 * i +: 8];
         exp_we_cyc   = c0 + ((size == 4) ? 1 : 2);
         exp_resp_cyc = exp_we_cyc + 1;
         exp_rdata    = '0;
         exp_fault    = 1'b0;
      end
      busy_until = exp_resp_cyc;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         chk("we_during_reset", bus.mem_write_enable, 1'b0);
         if (exp_resp_cyc >= cyc) n_accepted--;
         exp_resp_cyc = -1;
         exp_we_cyc   = -1;
         busy_until   = -1;
         after_reset  = 1'b1;
      end else begin
         if (after_reset) begin
            chk("reset_resp_rdata", bus.resp_rdata, '0);
            chk("reset_resp_fault", bus.resp_fault, 1'b0);
            chk("reset_write_addr", bus.mem_write_addr, '0);
            chk("reset_write_data", bus.mem_write_data, '0);
            after_reset = 1'b0;
         end
         chk("req_ready", bus.req_ready, cyc > busy_until);
         chk("resp_valid", bus.resp_valid, cyc == exp_resp_cyc);
         if (bus.resp_valid) n_resp++;
         if (cyc == exp_resp_cyc) begin
            chk("resp_rdata", bus.resp_rdata, exp_rdata);
            chk("resp_fault", bus.resp_fault, exp_fault);
         end
         chk("mem_write_enable", bus.mem_write_enable, cyc == exp_we_cyc);
         if (cyc == exp_we_cyc) begin
            chk("mem_write_addr", bus.mem_write_addr, exp_waddr);
            chk("mem_write_data", bus.mem_write_data, exp_wdata);
            for (int i = 0; i < 4; i++) ref_mem[exp_waddr + i] = exp_wdata[8 * i +: 8];
         end
         if (cyc > busy_until) begin
            chk("mem_read_addr", bus.mem_read_addr, {bus.req_addr[31:2], 2'b00});
            if (bus.req_valid) model_accept(cyc);
         end
      end
   end

   task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      bus.req_valid    = 1'b1;
      bus.req_is_store = st;
      bus.req_funct3   = f3;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
   endtask

   // one request with literal expectations: result, latency, write cycle and word
   task automatic txn(input string nm, input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] e_rdata, input logic e_fault,
                      input int e_lat, input int e_wcyc, input logic [31:0] e_wdata);
      int          hs, lat, wcyc, nwe;
      logic [31:0] rd, wdat;
      logic        flt;
      bit          got;
      @(posedge clk);
      #1;
      drive(st, f3, a, wd);
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         got = bus.req_ready;
      end
      hs = cyc;
      chk({nm, "_accept"}, got, 1'b1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      got = 1'b0; nwe = 0; lat = -1; wcyc = -1; rd = '0; flt = 1'b0; wdat = '0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         if (bus.mem_write_enable) begin
            nwe++;
            wcyc = cyc - hs;
            wdat = bus.mem_write_data;
         end
         if (bus.resp_valid) begin
            got = 1'b1;
            lat = cyc - hs;
            rd  = bus.resp_rdata;
            flt = bus.resp_fault;
         end
      end
      chk({nm, "_latency"}, lat, e_lat);
      chk({nm, "_rdata"}, rd, e_rdata);
      chk({nm, "_fault"}, flt, e_fault);
      chk({nm, "_write_count"}, nwe, (e_wcyc > 0) ? 1 : 0);
      if (e_wcyc > 0) begin
         chk({nm, "_write_cycle"}, wcyc, e_wcyc);
         chk({nm, "_write_word"}, wdat, e_wdata);
      end
   endtask

   task automatic stream_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      bit got;
      drive(st, f3, a, wd);
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         got = bus.req_ready;
      end
      chk("stream_accept", got, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  nwe, nrsp;
      bit  got;
      bus.req_valid    = 1'b0;
      bus.req_is_store = 1'b0;
      bus.req_funct3   = 3'b000;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      txn("sw_10",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1, 32'hDEAD_BEEF);
      txn("lw_10",  1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0);
      txn("lb_13",  1'b0, 3'b000, 32'h13, 32'h0,         32'hFFFF_FFDE, 1'b0, 2, 0, 32'h0);
      txn("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0,         32'h0000_00DE, 1'b0, 2, 0, 32'h0);
      txn("lh_10",  1'b0, 3'b001, 32'h10, 32'h0,         32'hFFFF_BEEF, 1'b0, 2, 0, 32'h0);
      txn("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0,         32'h0000_DEAD, 1'b0, 2, 0, 32'h0);
      txn("sb_11",  1'b1, 3'b000, 32'h11, 32'h1234_5678, 32'h0,         1'b0, 3, 2, 32'hDEAD_78EF);
      txn("sh_12",  1'b1, 3'b001, 32'h12, 32'hAAAA_5555, 32'h0,         1'b0, 3, 2, 32'h5555_78EF);
      txn("lw_rmw", 1'b0, 3'b010, 32'h10, 32'h0,         32'h5555_78EF, 1'b0, 2, 0, 32'h0);

      txn("f_lw_02",   1'b0, 3'b010, 32'h02,  32'h0,  32'h0, 1'b1, 1, 0, 32'h0);
      txn("f_sh_21",   1'b1, 3'b001, 32'h21,  32'h55, 32'h0, 1'b1, 1, 0, 32'h0);
      txn("f_lw_200",  1'b0, 3'b010, 32'h200, 32'h0,  32'h0, 1'b1, 1, 0, 32'h0);
      txn("f_ld_011",  1'b0, 3'b011, 32'h10,  32'h0,  32'h0, 1'b1, 1, 0, 32'h0);
      txn("f_st_100",  1'b1, 3'b100, 32'h10,  32'h77, 32'h0, 1'b1, 1, 0, 32'h0);
      txn("lh_1fe",    1'b0, 3'b001, 32'h1FE, 32'h0,  32'h0, 1'b0, 2, 0, 32'h0);

      // SB dropped by reset in its WRITE cycle
      @(posedge clk);
      #1;
      drive(1'b1, 3'b000, 32'h10, 32'h99);
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         got = bus.req_ready;
      end
      chk("rst_sb_accept", got, 1'b1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      nwe = 0;
      nrsp = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.mem_write_enable) nwe++;
         if (bus.resp_valid) nrsp++;
      end
      chk("rst_no_write", nwe, 0);
      chk("rst_no_resp", nrsp, 0);
      chk("rst_ready", bus.req_ready, 1'b1);
      txn("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'h5555_78EF, 1'b0, 2, 0, 32'h0);

      // req_valid held high across a mixed sequence
      @(posedge clk);
      #1;
      stream_req(1'b1, 3'b010, 32'h20, 32'h1122_3344);
      stream_req(1'b0, 3'b000, 32'h21, 32'h0);
      stream_req(1'b1, 3'b001, 32'h22, 32'h0000_BEEF);
      stream_req(1'b0, 3'b101, 32'h22, 32'h0);
      stream_req(1'b1, 3'b000, 32'h20, 32'h0000_0080);
      stream_req(1'b0, 3'b000, 32'h20, 32'h0);
      stream_req(1'b0, 3'b001, 32'h23, 32'h0);
      stream_req(1'b0, 3'b010, 32'h20, 32'h0);
      bus.req_valid = 1'b0;
      repeat (6) @(posedge clk);
      txn("lw_stream", 1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF_3380, 1'b0, 2, 0, 32'h0);

      repeat (3) @(posedge clk);
      chk("resp_per_request", n_resp, n_accepted);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end
endmodule
